// File: rtl/count_event_monitor.sv
// Watches a 4-bit counter value, classifies each edge-to-edge transition and
// queues notable ones (match/wrap/restart/error) in a show-ahead event FIFO.
module count_event_monitor #(
    parameter int         FIFO_DEPTH  = 4,
    parameter logic [3:0] MATCH_VALUE = 4'd9
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic [3:0] Q_in,
    input  logic       evt_ready,
    output logic       evt_valid,
    output logic [5:0] evt_data,
    output logic [7:0] wrap_count,
    output logic [7:0] err_count,
    output logic       overflow
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);

    localparam logic [1:0] T_WRAP    = 2'b00;
    localparam logic [1:0] T_MATCH   = 2'b01;
    localparam logic [1:0] T_RESTART = 2'b10;
    localparam logic [1:0] T_ERROR   = 2'b11;

    logic [3:0]    r_prev_q;
    logic          r_prev_valid;
    logic [5:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic [7:0]    r_wrap_count;
    logic [7:0]    r_err_count;
    logic          r_overflow;

    logic [3:0]    w_prev_inc;
    logic          w_evt_gen;
    logic [1:0]    w_evt_type;
    logic          w_is_wrap;
    logic          w_is_err;
    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;

    assign w_prev_inc = r_prev_q + 4'd1;

    // Checks are ordered so each branch may rely on the earlier ones having
    // failed; 15->0 is caught as WRAP before the generic "+1" step test.
    always_comb begin
        w_evt_gen  = 1'b0;
        w_evt_type = T_WRAP;
        w_is_wrap  = 1'b0;
        w_is_err   = 1'b0;
        if (r_prev_valid && (Q_in != r_prev_q)) begin
            if ((r_prev_q == 4'hF) && (Q_in == 4'h0)) begin
                w_evt_gen  = 1'b1;
                w_evt_type = T_WRAP;
                w_is_wrap  = 1'b1;
            end else if (Q_in == w_prev_inc) begin
                if (Q_in == MATCH_VALUE) begin
                    w_evt_gen  = 1'b1;
                    w_evt_type = T_MATCH;
                end
            end else if (Q_in == 4'h0) begin
                w_evt_gen  = 1'b1;
                w_evt_type = T_RESTART;
            end else begin
                w_evt_gen  = 1'b1;
                w_evt_type = T_ERROR;
                w_is_err   = 1'b1;
            end
        end
    end

    // Output handshake: evt_data is meaningful whenever evt_valid is high; an
    // entry is consumed on a rising edge where evt_valid && evt_ready. A full
    // FIFO still accepts a new event in a cycle where the head is popped.
    assign w_full = (r_count == DEPTH_C);
    assign w_pop  = evt_valid && evt_ready;
    assign w_push = w_evt_gen && (!w_full || w_pop);
    assign w_drop = w_evt_gen && w_full && !w_pop;

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_prev_q     <= 4'h0;
            r_prev_valid <= 1'b0;
        end else begin
            r_prev_q     <= Q_in;
            r_prev_valid <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= 6'd0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= {w_evt_type, Q_in};
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + (AW + 1)'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - (AW + 1)'(1);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Tallies count classifications, independent of whether the FIFO kept them.
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_wrap_count <= 8'd0;
            r_err_count  <= 8'd0;
        end else begin
            if (w_is_wrap && (r_wrap_count != 8'hFF)) begin
                r_wrap_count <= r_wrap_count + 8'd1;
            end
            if (w_is_err && (r_err_count != 8'hFF)) begin
                r_err_count <= r_err_count + 8'd1;
            end
        end
    end

    assign evt_valid  = (r_count != '0);
    assign evt_data   = r_mem[r_rd_ptr];
    assign wrap_count = r_wrap_count;
    assign err_count  = r_err_count;
    assign overflow   = r_overflow;

endmodule

// File: doc/count_event_monitor.md
# count_event_monitor

Downstream consumer of the four_bit_counter output. It samples the counter's 4-bit value every clock and classifies each transition as hold, step, wrap, restart or illegal jump. Notable transitions are queued as event words in a small show-ahead FIFO with a valid/ready output handshake. It also keeps saturating wrap and error tallies and a sticky overflow flag, for use by later checker and display stages.

## Interface
- FIFO_DEPTH, 4, event FIFO entries; power of two, ≥2
- MATCH_VALUE, 4'd9, count value that raises a MATCH event when reached by a normal step

- CLK  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; one clock; reset is synchronous and active-high
- Q_in  input  4  counter value (connects to four_bit_counter Q)
- evt_ready  input  1  consumer accepts head event this cycle
- evt_valid  output  1  FIFO non-empty
- evt_data  output  6  {type[1:0], value[3:0]}; head of FIFO
- wrap_count  output  8  number of WRAP events, saturates at 255
- err_count  output  8  number of ERROR events, saturates at 255
- overflow  output  1  sticky; an event was dropped because the FIFO was full

## Operation
- Internal state: prev_q[3:0], prev_valid, FIFO storage/pointers/occupancy, two counters, overflow.
- Priming:
  - The first clock after reset deasserts only loads prev_q ← Q_in and sets prev_valid.
  - No classification happens on that edge.
- Classification each edge with prev_valid=1, comparing Q_in against prev_q:
  - HOLD: Q_in == prev_q. No event.
  - WRAP: prev_q == 15 and Q_in == 0. Event type 2'b00.
  - STEP: Q_in == prev_q+1 and prev_q != 15. If Q_in == MATCH_VALUE, event type 2'b01 (MATCH). Otherwise no event.
  - RESTART: Q_in == 0, prev_q ∉ {0, 15}. Event type 2'b10. Covers the counter's asynchronous reset.
  - ERROR: any other transition. Event type 2'b11.
  - The categories are mutually exclusive, so at most one event per cycle.
  - If MATCH_VALUE == 0, a 15→0 transition is WRAP only.
- Event word: value field = Q_in sampled at the triggering edge.
- prev_q ← Q_in on every edge when not in reset.
- FIFO behaviour:
  - Show-ahead: evt_data is valid whenever evt_valid=1.
  - Pop: when evt_valid && evt_ready.
  - Push: when an event is generated and (not full, or pop in the same cycle).
  - Full with simultaneous pop: the push is accepted and occupancy is unchanged.
  - Full without pop: the event is dropped and overflow ← 1. Overflow clears only on reset.
  - Empty FIFO: pop is ignored. evt_ready with evt_valid=0 has no effect.
  - evt_data is don't-care when evt_valid=0. The bench must not check it then.
  - Order is strictly first-in, first-out.
- Counters:
  - wrap_count increments on each WRAP classification; err_count increments on each ERROR classification.
  - Both increment even if the event is dropped by the FIFO.
  - Both saturate at 8'hFF and never wrap.
- Reset, including mid-operation:
  - prev_valid=0, prev_q=0.
  - FIFO emptied (evt_valid=0), evt_data=0.
  - wrap_count=0, err_count=0, overflow=0.
  - Any pending or queued events are discarded.

## Timing
- Q_in is sampled at rising edge N and compared with the value sampled at edge N−1.
- The resulting event is visible on evt_valid/evt_data immediately after edge N: one-edge latency from sampling to output.
- Counter outputs update at the same edge N.
- A pop at edge M exposes the next entry (or evt_valid=0) right after edge M.
- Outputs are registered, with no combinational path from Q_in or evt_ready to any output.
- After reset deasserts, the earliest possible event appears after the 2nd rising edge (priming edge + classifying edge).
- Throughput: one event per cycle in and one per cycle out, sustained.

## Test plan
- Free-run from 0 through 15, back to 0, to 3, with evt_ready=1:
  - Exactly two events, in order: {01,1001} then {00,0000}.
  - wrap_count=1, err_count=0, overflow=0.
- Hold Q_in=5 for 8 cycles, then step to 6:
  - No events; evt_valid stays 0.
  - Counters unchanged.
- Count 0..7, then force Q_in=0 (counter async reset):
  - One RESTART event {10,0000}.
  - wrap_count stays 0.
- Jump 3→7, then 7→2, with evt_ready=0:
  - Two queued events, {11,0111} then {11,0010}.
  - err_count=2.
  - Raising evt_ready drains them in that order over 2 cycles.
- evt_ready=0, generate 5 events (e.g. 5 errors):
  - 4 events retained and overflow=1.
  - err_count=5.
  - A simultaneous pop and push when full: occupancy stays 4 and the new event is at the tail.
- Mid-operation reset with 3 events queued and wrap_count=2:
  - Next cycle: evt_valid=0, wrap_count=0, err_count=0, overflow=0.
  - Reset held high for 3 cycles: no events during reset.
  - First event possible only after two post-reset edges.
